// File: rtl/output_writeback_pkg.sv
// Shared constants and FSM encoding for the output writeback path.
package output_writeback_pkg;

    localparam int unsigned ARRAY_WIDTH   = 8;
    localparam int unsigned ACC_WIDTH     = 32;

    // Layer geometry: tile grid times rows drained per tile.
    localparam int unsigned TILE_ROWS     = 8;
    localparam int unsigned TILE_COLS     = 25;
    localparam int unsigned ROWS_PER_TILE = 8;
    localparam int unsigned TOTAL_BEATS   = TILE_ROWS * TILE_COLS * ROWS_PER_TILE;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Storage array, no reset needed: contents are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/output_writeback.sv
// Requantises drained accumulator rows to int8, packs them and writes them to the result BRAM.
module output_writeback
    import output_writeback_pkg::*;
#(
    parameter int unsigned ARRAY_WIDTH = output_writeback_pkg::ARRAY_WIDTH,
    parameter int unsigned ACC_WIDTH   = output_writeback_pkg::ACC_WIDTH,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned TOTAL_BEATS = output_writeback_pkg::TOTAL_BEATS,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             relu_en,
    input  logic [4:0]                       shift,
    input  logic                             in_valid,
    input  logic [ACC_WIDTH*ARRAY_WIDTH-1:0] in_data,
    input  logic                             wr_ready,
    output logic                             wr_en,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [8*ARRAY_WIDTH-1:0]         wr_data,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      sat_count,
    output logic                             overflow
);

    localparam int unsigned OUT_W  = 8 * ARRAY_WIDTH;
    localparam int unsigned RW     = ACC_WIDTH + 1;
    localparam int unsigned BEAT_W = $clog2(TOTAL_BEATS + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PEND_W = CNT_W + 2;

    localparam logic [BEAT_W-1:0]     BEATS_END = BEAT_W'(TOTAL_BEATS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_BEATS - 1);
    localparam logic signed [RW-1:0]  SAT_HI    = RW'(127);
    localparam logic signed [RW-1:0]  SAT_LO    = RW'(-128);

    wb_state_e             state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [4:0]            shift_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           sat_q;

    logic                  s1_valid_q;
    logic signed [RW-1:0]  r_d [ARRAY_WIDTH];
    logic signed [RW-1:0]  r_q [ARRAY_WIDTH];
    logic                  s2_valid_q;
    logic [OUT_W-1:0]      s2_data_d;
    logic [OUT_W-1:0]      s2_data_q;
    logic [ARRAY_WIDTH-1:0] lane_sat;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  pop;

    logic signed [RW-1:0]  round_term;
    logic [PEND_W-1:0]     pending;
    logic                  room;
    logic                  row_in;
    logic                  row_accept;
    logic                  row_drop;
    logic                  drain_done;
    logic [16:0]           sat_sum;
    logic [15:0]           sat_next;

    assign pop = !fifo_empty && wr_ready;

    // Rows already in stage 1/2 have a FIFO slot reserved, so admission looks at all of them.
    assign pending    = PEND_W'(fifo_count) + PEND_W'(s1_valid_q) + PEND_W'(s2_valid_q);
    assign room       = !(fifo_full && !pop) && (pending < PEND_W'(FIFO_DEPTH) + PEND_W'(pop));
    assign row_in     = in_valid && (state_q == StRun);
    assign row_accept = row_in && room;
    assign row_drop   = row_in && !room;

    // Layer is finished once nothing is in flight and the last buffered word leaves this cycle.
    assign drain_done = !s1_valid_q && !s2_valid_q
                        && (fifo_empty || (fifo_count == CNT_W'(1) && pop));

    assign round_term = (shift_q == 5'd0) ? '0 : (RW'(1) << (shift_q - 5'd1));

    for (genvar i = 0; i < ARRAY_WIDTH; i++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] v;
        logic signed [ACC_WIDTH-1:0] v_relu;
        logic signed [RW-1:0]        v_ext;
        logic signed [RW-1:0]        sum;
        logic                        hi;
        logic                        lo;

        // Stage 1: ReLU then rounding shift, one bit wider so the round add cannot wrap.
        assign v      = in_data[i*ACC_WIDTH +: ACC_WIDTH];
        assign v_relu = (relu_en && v[ACC_WIDTH-1]) ? '0 : v;
        assign v_ext  = {v_relu[ACC_WIDTH-1], v_relu};
        assign sum    = v_ext + round_term;
        assign r_d[i] = sum >>> shift_q;

        // Stage 2: clamp to int8.
        assign hi          = r_q[i] > SAT_HI;
        assign lo          = r_q[i] < SAT_LO;
        assign lane_sat[i] = hi || lo;
        assign s2_data_d[8*i +: 8] = hi ? 8'h7F : (lo ? 8'h80 : r_q[i][7:0]);
    end

    assign sat_sum  = {1'b0, sat_q} + 17'($countones(lane_sat));
    assign sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

    // Two-stage requantisation pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            for (int i = 0; i < ARRAY_WIDTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= row_accept;
            s2_valid_q <= s1_valid_q;
            if (row_accept) begin
                for (int i = 0; i < ARRAY_WIDTH; i++) begin
                    r_q[i] <= r_d[i];
                end
            end
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
            end
        end
    end

    // Layer control FSM with its registered status outputs, beat/address/saturation counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            shift_q    <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
            sat_q      <= '0;
        end else begin
            if (pop && addr_q != LAST_ADDR) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
            end
            if (s1_valid_q) begin
                sat_q <= sat_next;
            end
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StRun;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        shift_q    <= shift;
                        beat_q     <= '0;
                        addr_q     <= '0;
                        sat_q      <= '0;
                    end
                end
                StRun: begin
                    if (row_in) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (row_drop) begin
                            overflow_q <= 1'b1;
                        end
                        if (beat_q + BEAT_W'(1) == BEATS_END) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_valid_q),
        .push_data (s2_data_q),
        .pop       (pop),
        .pop_data  (wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr_en     = !fifo_empty;
    assign wr_addr   = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_count = sat_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_output_writeback.sv
// Directed bench for output_writeback: latency, requantisation, backpressure, full layers, reset.
module tb_output_writeback;

    localparam int unsigned NL  = 8;
    localparam int unsigned ACW = 32;
    localparam int unsigned ADW = 12;
    localparam int unsigned TB  = 1600;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              relu_en = 1'b0;
    logic [4:0]        shift = '0;
    logic              in_valid = 1'b0;
    logic [ACW*NL-1:0] in_data = '0;
    logic              wr_ready = 1'b1;
    logic              wr_en;
    logic [ADW-1:0]    wr_addr;
    logic [8*NL-1:0]   wr_data;
    logic              busy;
    logic              done;
    logic [15:0]       sat_count;
    logic              overflow;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_writes = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    int hits [0:4095];
    logic [63:0] data_log [0:4095];

    always #5 clk = ~clk;

    output_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .relu_en   (relu_en),
        .shift     (shift),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Logs the write completing at the coming edge, then advances one cycle.
    task automatic tick();
        if (wr_en && wr_ready) begin
            hits[wr_addr]++;
            data_log[wr_addr] = wr_data;
            n_writes++;
            last_wr_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        for (int a = 0; a < 4096; a++) hits[a] = 0;
        n_writes = 0;
    endtask

    function automatic logic [ACW*NL-1:0] row8(input logic [31:0] a0, input logic [31:0] a1,
                                               input logic [31:0] a2, input logic [31:0] a3,
                                               input logic [31:0] a4, input logic [31:0] a5,
                                               input logic [31:0] a6, input logic [31:0] a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [ACW*NL-1:0] row_all(input logic [31:0] v);
        return {NL{v}};
    endfunction

    task automatic send_row(input logic [ACW*NL-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pulse_start(input logic [4:0] sh);
        start = 1'b1;
        shift = sh;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 50) begin
            tick();
            k++;
        end
        check(tag, 64'(done), 64'd1);
        done_cyc = cyc;
    endtask

    initial begin
        int bad;

        // Reset state
        ticks(3);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_addr", 64'(wr_addr), 64'd0);
        rst = 1'b1;
        tick();

        // Layer A, shift 4
        clear_log();
        pulse_start(5'd4);
        check("a_busy", 64'(busy), 64'd1);
        in_valid = 1'b1;
        in_data  = row8(100, -100, 2047, -2049, 8, 7, 0, -8);
        tick();
        in_valid = 1'b0;
        tick();
        check("lat_early", 64'(wr_en), 64'd0);
        tick();
        check("lat_wr_en", 64'(wr_en), 64'd1);
        check("row1_addr", 64'(wr_addr), 64'd0);
        check("row1_data", wr_data, 64'h0000_0001_807F_FA06);
        // Lane 3 rounds to exactly -128, so only lane 2 clamps.
        check("row1_sat", 64'(sat_count), 64'd1);
        tick();
        check("row1_addr_inc", 64'(wr_addr), 64'd1);
        check("row1_idle", 64'(wr_en), 64'd0);

        // ReLU on a negative lane, positive lane saturating
        relu_en = 1'b1;
        send_row(row8(-50, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0));
        relu_en = 1'b0;
        ticks(2);
        check("relu_data", wr_data, 64'h0000_0000_0000_7F00);
        check("relu_sat", 64'(sat_count), 64'd2);
        tick();

        // Backpressure: 6 rows while the write port is stalled
        wr_ready = 1'b0;
        for (int k = 1; k <= 6; k++) send_row(row_all(32'(k * 16)));
        wr_ready = 1'b1;
        check("bp_overflow", 64'(overflow), 64'd1);
        ticks(8);
        check("bp_writes", 64'(n_writes), 64'd6);
        for (int j = 0; j < 4; j++) begin
            logic [7:0] b;
            b = 8'(j + 1);
            check("bp_data", data_log[2+j], {8{b}});
        end
        check("bp_drained", 64'(wr_en), 64'd0);

        // start during RUN is ignored: counters and latched shift survive
        pulse_start(5'd0);
        check("rerun_busy", 64'(busy), 64'd1);
        check("rerun_addr", 64'(wr_addr), 64'd6);
        send_row(row_all(32));
        ticks(2);
        check("rerun_shift", wr_data, {8{8'h02}});
        tick();

        // Remaining beats of layer A (9 used so far)
        for (int k = 0; k < int'(TB) - 10; k++) send_row('0);
        check("a_not_done", 64'(done), 64'd0);
        send_row('0);
        wait_done("a_done");
        check("a_done_lat", 64'(done_cyc), 64'(last_wr_cyc + 1));
        check("a_ovf_sticky", 64'(overflow), 64'd1);
        check("a_writes", 64'(n_writes), 64'(TB - 2));
        check("a_addr_end", 64'(wr_addr), 64'(TB - 2));
        check("a_busy_off", 64'(busy), 64'd0);
        check("a_sat_end", 64'(sat_count), 64'd2);

        // start in DONE: layer B, shift 31 with ReLU
        clear_log();
        relu_en = 1'b1;
        pulse_start(5'd31);
        check("b_done_clr", 64'(done), 64'd0);
        check("b_busy", 64'(busy), 64'd1);
        check("b_ovf_clr", 64'(overflow), 64'd0);
        check("b_sat_clr", 64'(sat_count), 64'd0);
        send_row(row8(32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 0, 0, 0, 0, 0));
        relu_en = 1'b0;
        for (int k = 1; k < int'(TB); k++) send_row('0);
        wait_done("b_done");
        check("b_done_lat", 64'(done_cyc), 64'(last_wr_cyc + 1));
        check("b_first_data", data_log[0], 64'h0000_0000_0001_0001);
        bad = 0;
        for (int a = 0; a < int'(TB); a++) if (hits[a] != 1) bad++;
        check("b_addr_once", 64'(bad), 64'd0);
        check("b_writes", 64'(n_writes), 64'(TB));
        check("b_ovf", 64'(overflow), 64'd0);
        check("b_addr_clamp", 64'(wr_addr), 64'(TB - 1));

        // Layer C: asynchronous reset at beat 700
        clear_log();
        pulse_start(5'd0);
        for (int k = 0; k < 700; k++) send_row('0);
        check("c_addr_pre", 64'(wr_addr), 64'd697);
        check("c_busy_pre", 64'(busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("c_rst_wr_en", 64'(wr_en), 64'd0);
        check("c_rst_busy", 64'(busy), 64'd0);
        check("c_rst_done", 64'(done), 64'd0);
        check("c_rst_addr", 64'(wr_addr), 64'd0);
        #1;
        rst = 1'b1;
        tick();
        clear_log();
        pulse_start(5'd4);
        send_row(row_all(16));
        ticks(2);
        check("c_restart_en", 64'(wr_en), 64'd1);
        check("c_restart_addr", 64'(wr_addr), 64'd0);
        check("c_restart_data", wr_data, {8{8'h01}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
